// File: rtl/accum_ctrl_pkg.sv
// ---------------------------------------------------------------------------
// accum_ctrl_pkg : opcodes, state encoding and control-word fields for the
// accumulator CPU control unit (ACCUM_ILLEGAL_TRAP_EN adds the TRAP state).
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

package accum_ctrl_pkg;

   localparam logic [3:0] OP_HALT = 4'h0;
   localparam logic [3:0] OP_LDA  = 4'h1;
   localparam logic [3:0] OP_STA  = 4'h2;
   localparam logic [3:0] OP_ADD  = 4'h3;
   localparam logic [3:0] OP_SUB  = 4'h4;
   localparam logic [3:0] OP_AND  = 4'h5;
   localparam logic [3:0] OP_ORR  = 4'h6;
   localparam logic [3:0] OP_ADDI = 4'h7;
   localparam logic [3:0] OP_BEQ  = 4'h8;
   localparam logic [3:0] OP_BNE  = 4'h9;
   localparam logic [3:0] OP_JMP  = 4'hA;
   localparam logic [3:0] OP_PUSH = 4'hB;
   localparam logic [3:0] OP_POP  = 4'hC;

   typedef enum logic [3:0] {
      ST_INIT     = 4'd0,
      ST_FETCH    = 4'd1,
      ST_DECODE   = 4'd2,
      ST_MEM_RD   = 4'd3,
      ST_EXEC     = 4'd4,
      ST_MEM_WR   = 4'd5,
      ST_EXEC_I   = 4'd6,
      ST_BRANCH   = 4'd7,
      ST_JUMP     = 4'd8,
      ST_PUSH_DEC = 4'd9,
      ST_PUSH_WR  = 4'd10,
      ST_POP_ADR  = 4'd11,
      ST_POP_RD   = 4'd12,
      ST_POP_WB   = 4'd13,
      ST_HALT     = 4'd14
`ifdef ACCUM_ILLEGAL_TRAP_EN
      ,
      ST_TRAP     = 4'd15
`endif
   } state_e;

   localparam logic [1:0] PCSRC_ALU    = 2'd0;
   localparam logic [1:0] PCSRC_ZE     = 2'd1;
   localparam logic [1:0] PCSRC_ALUOUT = 2'd2;

   localparam logic [1:0] MADDR_PC     = 2'd0;
   localparam logic [1:0] MADDR_SEL    = 2'd1;
   localparam logic [1:0] MADDR_ALUOUT = 2'd2;

   localparam logic       MDATA_ACC    = 1'b0;

   localparam logic [1:0] SRCA_PC      = 2'd0;
   localparam logic [1:0] SRCA_ACC     = 2'd1;
   localparam logic [1:0] SRCA_SP      = 2'd2;

   localparam logic [2:0] SRCB_STEP    = 3'd0;
   localparam logic [2:0] SRCB_MDR     = 3'd1;
   localparam logic [2:0] SRCB_SE      = 3'd2;
   localparam logic [2:0] SRCB_ZE      = 3'd3;
   localparam logic [2:0] SRCB_SL1     = 3'd4;
   localparam logic [2:0] SRCB_ZERO    = 3'd5;

   localparam logic [2:0] ALU_ADD      = 3'd0;
   localparam logic [2:0] ALU_SUB      = 3'd1;
   localparam logic [2:0] ALU_AND      = 3'd2;
   localparam logic [2:0] ALU_OR       = 3'd3;
   localparam logic [2:0] ALU_PASSB    = 3'd4;

   typedef struct packed {
      logic       pc_write;
      logic       branch;
      logic       bne_or_beq;
      logic [1:0] pc_src;
      logic       ir_write;
      logic [1:0] mem_addr;
      logic       mem_data;
      logic       mem_write;
      logic       acc_write;
      logic       sp_write;
      logic [1:0] alu_src_a;
      logic [2:0] alu_src_b;
      logic [2:0] alu_op;
   } ctrl_word_t;

   localparam ctrl_word_t CTRL_IDLE = '0;

   // ALU operation for the register-memory instructions finishing in EXEC.
   function automatic logic [2:0] exec_alu_op(input logic [3:0] op);
      logic [2:0] alu;
      case (op)
         OP_LDA:  alu = ALU_PASSB;
         OP_ADD:  alu = ALU_ADD;
         OP_SUB:  alu = ALU_SUB;
         OP_AND:  alu = ALU_AND;
         OP_ORR:  alu = ALU_OR;
         default: alu = ALU_ADD;
      endcase
      return alu;
   endfunction

endpackage

`default_nettype wire

// File: rtl/accum_ctrl_decode.sv
// ---------------------------------------------------------------------------
// accum_ctrl_decode : combinational map from (state, latched opcode) to the
// datapath control word. Anything not driven in a state stays 0.
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module accum_ctrl_decode
   import accum_ctrl_pkg::*;
(
   input  state_e     state,
   input  logic [3:0] op_q,
   output ctrl_word_t ctrl
);

   always_comb begin
      ctrl = CTRL_IDLE;
      case (state)
         ST_FETCH: begin
            ctrl.mem_addr  = MADDR_PC;
            ctrl.ir_write  = 1'b1;
            ctrl.alu_src_a = SRCA_PC;
            ctrl.alu_src_b = SRCB_STEP;
            ctrl.alu_op    = ALU_ADD;
            ctrl.pc_src    = PCSRC_ALU;
            ctrl.pc_write  = 1'b1;
         end
         // Speculative branch target computed here lands in ALUOut.
         ST_DECODE: begin
            ctrl.alu_src_a = SRCA_PC;
            ctrl.alu_src_b = SRCB_SL1;
            ctrl.alu_op    = ALU_ADD;
         end
         ST_MEM_RD: begin
            ctrl.mem_addr  = MADDR_SEL;
         end
         ST_EXEC: begin
            ctrl.alu_src_a = SRCA_ACC;
            ctrl.alu_src_b = SRCB_MDR;
            ctrl.alu_op    = exec_alu_op(op_q);
            ctrl.acc_write = 1'b1;
         end
         ST_MEM_WR: begin
            ctrl.mem_addr  = MADDR_SEL;
            ctrl.mem_data  = MDATA_ACC;
            ctrl.mem_write = 1'b1;
         end
         ST_EXEC_I: begin
            ctrl.alu_src_a = SRCA_ACC;
            ctrl.alu_src_b = SRCB_SE;
            ctrl.alu_op    = ALU_ADD;
            ctrl.acc_write = 1'b1;
         end
         // Zero is resolved by the PC block, so taken/not-taken look alike here.
         ST_BRANCH: begin
            ctrl.alu_src_a  = SRCA_ACC;
            ctrl.alu_src_b  = SRCB_ZERO;
            ctrl.alu_op     = ALU_SUB;
            ctrl.branch     = 1'b1;
            ctrl.bne_or_beq = op_q[0];
            ctrl.pc_src     = PCSRC_ALUOUT;
         end
         ST_JUMP: begin
            ctrl.pc_src   = PCSRC_ZE;
            ctrl.pc_write = 1'b1;
         end
         ST_PUSH_DEC: begin
            ctrl.alu_src_a = SRCA_SP;
            ctrl.alu_src_b = SRCB_STEP;
            ctrl.alu_op    = ALU_SUB;
            ctrl.sp_write  = 1'b1;
         end
         ST_PUSH_WR: begin
            ctrl.mem_addr  = MADDR_ALUOUT;
            ctrl.mem_data  = MDATA_ACC;
            ctrl.mem_write = 1'b1;
         end
         ST_POP_ADR: begin
            ctrl.alu_src_a = SRCA_SP;
            ctrl.alu_src_b = SRCB_ZERO;
            ctrl.alu_op    = ALU_ADD;
         end
         ST_POP_RD: begin
            ctrl.mem_addr  = MADDR_ALUOUT;
            ctrl.alu_src_a = SRCA_SP;
            ctrl.alu_src_b = SRCB_STEP;
            ctrl.alu_op    = ALU_ADD;
            ctrl.sp_write  = 1'b1;
         end
         ST_POP_WB: begin
            ctrl.alu_src_b = SRCB_MDR;
            ctrl.alu_op    = ALU_PASSB;
            ctrl.acc_write = 1'b1;
         end
         default: ctrl = CTRL_IDLE;
      endcase
   end

endmodule

`default_nettype wire

// File: rtl/accum_control_unit.sv
// ---------------------------------------------------------------------------
// accum_control_unit : multicycle Moore control FSM for the 16-bit
// accumulator CPU. Define ACCUM_ILLEGAL_TRAP_EN to trap opcodes D-F.
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module accum_control_unit
   import accum_ctrl_pkg::*;
#(
   parameter int PC_STEP = 2
)(
   input  logic       CLK,
   input  logic       reset,
   input  logic [3:0] opcode,
   input  logic       Zero,
   output logic       PCWrite,
   output logic       Branch,
   output logic       bneOrbeq,
   output logic [1:0] PCSrc,
   output logic       IRWrite,
   output logic [1:0] MemAddr,
   output logic       MemData,
   output logic       MemWrite,
   output logic       AccWrite,
   output logic       SpWrite,
   output logic [1:0] ALUSrcA,
   output logic [2:0] ALUSrcB,
   output logic [2:0] ALUOp,
   output logic       halted,
   output logic       illegal,
   output logic [3:0] state_dbg
);

   state_e     state_q, state_d;
   logic [3:0] op_q, op_d;
   logic       halted_q, halted_d;
   ctrl_word_t ctrl_w;

   // Zero only steers the PC block; PC_STEP is applied in the datapath adder.
   logic unused_inputs;
   assign unused_inputs = Zero ^ PC_STEP[0];

   always_comb begin
      state_d = state_q;
      op_d    = op_q;
      case (state_q)
         ST_INIT:     state_d = ST_FETCH;
         ST_FETCH:    state_d = ST_DECODE;
         ST_DECODE: begin
            op_d = opcode;
            case (opcode)
               OP_HALT:                        state_d = ST_HALT;
               OP_LDA, OP_ADD, OP_SUB,
               OP_AND, OP_ORR:                 state_d = ST_MEM_RD;
               OP_STA:                         state_d = ST_MEM_WR;
               OP_ADDI:                        state_d = ST_EXEC_I;
               OP_BEQ, OP_BNE:                 state_d = ST_BRANCH;
               OP_JMP:                         state_d = ST_JUMP;
               OP_PUSH:                        state_d = ST_PUSH_DEC;
               OP_POP:                         state_d = ST_POP_ADR;
`ifdef ACCUM_ILLEGAL_TRAP_EN
               default:                        state_d = ST_TRAP;
`else
               default:                        state_d = ST_FETCH;
`endif
            endcase
         end
         ST_MEM_RD:   state_d = ST_EXEC;
         ST_EXEC:     state_d = ST_FETCH;
         ST_MEM_WR:   state_d = ST_FETCH;
         ST_EXEC_I:   state_d = ST_FETCH;
         ST_BRANCH:   state_d = ST_FETCH;
         ST_JUMP:     state_d = ST_FETCH;
         ST_PUSH_DEC: state_d = ST_PUSH_WR;
         ST_PUSH_WR:  state_d = ST_FETCH;
         ST_POP_ADR:  state_d = ST_POP_RD;
         ST_POP_RD:   state_d = ST_POP_WB;
         ST_POP_WB:   state_d = ST_FETCH;
         ST_HALT:     state_d = ST_HALT;
`ifdef ACCUM_ILLEGAL_TRAP_EN
         ST_TRAP:     state_d = ST_TRAP;
`endif
         default:     state_d = ST_INIT;
      endcase
   end

`ifdef ACCUM_ILLEGAL_TRAP_EN
   logic illegal_q, illegal_d;

   always_comb begin
      illegal_d = illegal_q | (state_d == ST_TRAP);
      halted_d  = halted_q | (state_d == ST_HALT) | (state_d == ST_TRAP);
   end

   always_ff @(posedge CLK or negedge reset) begin
      if (!reset) begin
         state_q   <= ST_INIT;
         op_q      <= 4'h0;
         halted_q  <= 1'b0;
         illegal_q <= 1'b0;
      end else begin
         state_q   <= state_d;
         op_q      <= op_d;
         halted_q  <= halted_d;
         illegal_q <= illegal_d;
      end
   end

   assign illegal = illegal_q;
`else
   always_comb begin
      halted_d = halted_q | (state_d == ST_HALT);
   end

   always_ff @(posedge CLK or negedge reset) begin
      if (!reset) begin
         state_q  <= ST_INIT;
         op_q     <= 4'h0;
         halted_q <= 1'b0;
      end else begin
         state_q  <= state_d;
         op_q     <= op_d;
         halted_q <= halted_d;
      end
   end

   assign illegal = 1'b0;
`endif

   accum_ctrl_decode u_decode (
      .state (state_q),
      .op_q  (op_q),
      .ctrl  (ctrl_w)
   );

   assign PCWrite   = ctrl_w.pc_write;
   assign Branch    = ctrl_w.branch;
   assign bneOrbeq  = ctrl_w.bne_or_beq;
   assign PCSrc     = ctrl_w.pc_src;
   assign IRWrite   = ctrl_w.ir_write;
   assign MemAddr   = ctrl_w.mem_addr;
   assign MemData   = ctrl_w.mem_data;
   assign MemWrite  = ctrl_w.mem_write;
   assign AccWrite  = ctrl_w.acc_write;
   assign SpWrite   = ctrl_w.sp_write;
   assign ALUSrcA   = ctrl_w.alu_src_a;
   assign ALUSrcB   = ctrl_w.alu_src_b;
   assign ALUOp     = ctrl_w.alu_op;
   assign halted    = halted_q;
   assign state_dbg = state_q;

   a_pc_load_exclusive: assert property (@(posedge CLK) disable iff (!reset)
      !(PCWrite && Branch));
   a_no_write_during_fetch: assert property (@(posedge CLK) disable iff (!reset)
      !(MemWrite && IRWrite));

endmodule

`default_nettype wire

// File: tb/tb_accum_control_unit.sv
// ---------------------------------------------------------------------------
// tb_accum_control_unit : directed table-driven bench for accum_control_unit.
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module tb_accum_control_unit;

   typedef struct packed {
      logic [3:0] st;
      logic       pcw;
      logic       br;
      logic       bne;
      logic [1:0] pcsrc;
      logic       irw;
      logic [1:0] maddr;
      logic       mdata;
      logic       mwr;
      logic       accw;
      logic       spw;
      logic [1:0] srca;
      logic [2:0] srcb;
      logic [2:0] aluop;
      logic       halted;
      logic       illegal;
   } obs_t;

   typedef struct {
      logic [3:0] op;
      logic       zero;
      obs_t       exp;
   } vec_t;

   localparam obs_t E_INIT   = '0;
   localparam obs_t E_FETCH  = '{st:4'd1, pcw:1'b1, irw:1'b1, default:'0};
   localparam obs_t E_DECODE = '{st:4'd2, srcb:3'd4, default:'0};
   localparam obs_t E_MEMRD  = '{st:4'd3, maddr:2'd1, default:'0};
   localparam obs_t E_EX_LDA = '{st:4'd4, srca:2'd1, srcb:3'd1, aluop:3'd4, accw:1'b1, default:'0};
   localparam obs_t E_EX_ADD = '{st:4'd4, srca:2'd1, srcb:3'd1, aluop:3'd0, accw:1'b1, default:'0};
   localparam obs_t E_EX_SUB = '{st:4'd4, srca:2'd1, srcb:3'd1, aluop:3'd1, accw:1'b1, default:'0};
   localparam obs_t E_EX_AND = '{st:4'd4, srca:2'd1, srcb:3'd1, aluop:3'd2, accw:1'b1, default:'0};
   localparam obs_t E_EX_OR  = '{st:4'd4, srca:2'd1, srcb:3'd1, aluop:3'd3, accw:1'b1, default:'0};
   localparam obs_t E_MEMWR  = '{st:4'd5, maddr:2'd1, mwr:1'b1, default:'0};
   localparam obs_t E_EXECI  = '{st:4'd6, srca:2'd1, srcb:3'd2, accw:1'b1, default:'0};
   localparam obs_t E_BNE    = '{st:4'd7, srca:2'd1, srcb:3'd5, aluop:3'd1, br:1'b1, bne:1'b1, pcsrc:2'd2, default:'0};
   localparam obs_t E_BEQ    = '{st:4'd7, srca:2'd1, srcb:3'd5, aluop:3'd1, br:1'b1, pcsrc:2'd2, default:'0};
   localparam obs_t E_JUMP   = '{st:4'd8, pcsrc:2'd1, pcw:1'b1, default:'0};
   localparam obs_t E_PUSHD  = '{st:4'd9, srca:2'd2, aluop:3'd1, spw:1'b1, default:'0};
   localparam obs_t E_PUSHW  = '{st:4'd10, maddr:2'd2, mwr:1'b1, default:'0};
   localparam obs_t E_POPA   = '{st:4'd11, srca:2'd2, srcb:3'd5, default:'0};
   localparam obs_t E_POPR   = '{st:4'd12, maddr:2'd2, srca:2'd2, spw:1'b1, default:'0};
   localparam obs_t E_POPW   = '{st:4'd13, srcb:3'd1, aluop:3'd4, accw:1'b1, default:'0};
   localparam obs_t E_HALT   = '{st:4'd14, halted:1'b1, default:'0};
`ifdef ACCUM_ILLEGAL_TRAP_EN
   localparam obs_t E_TRAP   = '{st:4'd15, halted:1'b1, illegal:1'b1, default:'0};
`endif

   logic       CLK = 1'b0;
   logic       reset = 1'b0;
   logic [3:0] opcode = 4'h0;
   logic       Zero = 1'b0;
   logic       PCWrite, Branch, bneOrbeq, IRWrite, MemData, MemWrite;
   logic       AccWrite, SpWrite, halted, illegal;
   logic [1:0] PCSrc, MemAddr, ALUSrcA;
   logic [2:0] ALUSrcB, ALUOp;
   logic [3:0] state_dbg;

   int   checks = 0;
   int   errors = 0;
   obs_t act;
   vec_t vecs[$];

   accum_control_unit #(.PC_STEP(2)) dut (
      .CLK       (CLK),
      .reset     (reset),
      .opcode    (opcode),
      .Zero      (Zero),
      .PCWrite   (PCWrite),
      .Branch    (Branch),
      .bneOrbeq  (bneOrbeq),
      .PCSrc     (PCSrc),
      .IRWrite   (IRWrite),
      .MemAddr   (MemAddr),
      .MemData   (MemData),
      .MemWrite  (MemWrite),
      .AccWrite  (AccWrite),
      .SpWrite   (SpWrite),
      .ALUSrcA   (ALUSrcA),
      .ALUSrcB   (ALUSrcB),
      .ALUOp     (ALUOp),
      .halted    (halted),
      .illegal   (illegal),
      .state_dbg (state_dbg)
   );

   always #5 CLK = ~CLK;

   always_comb begin
      act = {state_dbg, PCWrite, Branch, bneOrbeq, PCSrc, IRWrite, MemAddr, MemData,
             MemWrite, AccWrite, SpWrite, ALUSrcA, ALUSrcB, ALUOp, halted, illegal};
   end

   task automatic check(input string name, input obs_t exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h (state %0d) expected %h (state %0d)",
                  name, act, act.st, exp, exp.st);
      end
   endtask

   task automatic step(input logic [3:0] op, input logic z);
      opcode = op;
      Zero   = z;
      @(posedge CLK);
      #1;
   endtask

   task automatic do_reset();
      @(negedge CLK);
      reset = 1'b0;
      @(negedge CLK);
      reset = 1'b1;
   endtask

   task automatic add(input logic [3:0] op, input logic z, input obs_t exp);
      vec_t v;
      v.op   = op;
      v.zero = z;
      v.exp  = exp;
      vecs.push_back(v);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog expired");
   end

   initial begin
      add(4'h1, 1'b0, E_FETCH); add(4'h1, 1'b0, E_DECODE);
      add(4'h1, 1'b0, E_MEMRD); add(4'h1, 1'b0, E_EX_LDA);
      add(4'h9, 1'b0, E_FETCH); add(4'h9, 1'b0, E_DECODE); add(4'h9, 1'b0, E_BNE);
      add(4'h8, 1'b1, E_FETCH); add(4'h8, 1'b1, E_DECODE); add(4'h8, 1'b1, E_BEQ);
      add(4'h3, 1'b0, E_FETCH); add(4'h3, 1'b0, E_DECODE);
      add(4'h3, 1'b0, E_MEMRD); add(4'h3, 1'b0, E_EX_ADD);
      add(4'h4, 1'b0, E_FETCH); add(4'h4, 1'b0, E_DECODE);
      add(4'h4, 1'b0, E_MEMRD); add(4'h4, 1'b0, E_EX_SUB);
      add(4'h5, 1'b0, E_FETCH); add(4'h5, 1'b0, E_DECODE);
      add(4'h5, 1'b0, E_MEMRD); add(4'h5, 1'b0, E_EX_AND);
      add(4'h6, 1'b0, E_FETCH); add(4'h6, 1'b0, E_DECODE);
      add(4'h6, 1'b0, E_MEMRD); add(4'h6, 1'b0, E_EX_OR);
      add(4'h2, 1'b0, E_FETCH); add(4'h2, 1'b0, E_DECODE); add(4'h2, 1'b0, E_MEMWR);
      add(4'h7, 1'b0, E_FETCH); add(4'h7, 1'b0, E_DECODE); add(4'h7, 1'b0, E_EXECI);
      add(4'hA, 1'b0, E_FETCH); add(4'hA, 1'b0, E_DECODE); add(4'hA, 1'b0, E_JUMP);
      add(4'hB, 1'b0, E_FETCH); add(4'hB, 1'b0, E_DECODE);
      add(4'hB, 1'b0, E_PUSHD); add(4'hB, 1'b0, E_PUSHW);
      add(4'hC, 1'b0, E_FETCH); add(4'hC, 1'b0, E_DECODE); add(4'hC, 1'b0, E_POPA);
      add(4'hC, 1'b0, E_POPR);  add(4'hC, 1'b0, E_POPW);
      add(4'h1, 1'b0, E_FETCH);

      // Reset held across several edges: everything idle.
      reset = 1'b0;
      #12;
      check("reset_state", E_INIT);
      @(negedge CLK);
      reset = 1'b1;
      #1;
      check("init_after_release", E_INIT);

      foreach (vecs[i]) begin
         step(vecs[i].op, vecs[i].zero);
         check($sformatf("vec%0d_op%h", i, vecs[i].op), vecs[i].exp);
      end

      // HALT: sticky until reset regardless of opcode.
      do_reset();
      step(4'h1, 1'b0); check("halt_fetch", E_FETCH);
      step(4'h0, 1'b0); check("halt_decode", E_DECODE);
      step(4'h0, 1'b0); check("halt_enter", E_HALT);
      for (int k = 0; k < 10; k++) begin
         step(4'($urandom_range(0, 15)), 1'($urandom_range(0, 1)));
         check($sformatf("halt_hold%0d", k), E_HALT);
      end

      // Asynchronous reset in the middle of PUSH_WR.
      do_reset();
      step(4'hB, 1'b0); check("arst_fetch", E_FETCH);
      step(4'hB, 1'b0); check("arst_decode", E_DECODE);
      step(4'hB, 1'b0); check("arst_pushd", E_PUSHD);
      step(4'hB, 1'b0); check("arst_pushw", E_PUSHW);
      #2;
      reset = 1'b0;
      #1;
      check("arst_mid_cycle", E_INIT);
      @(negedge CLK);
      reset = 1'b1;
      step(4'h1, 1'b0); check("arst_resume_fetch", E_FETCH);

      // Illegal opcode E.
      do_reset();
      step(4'hE, 1'b0); check("ill_fetch", E_FETCH);
      step(4'hE, 1'b0); check("ill_decode", E_DECODE);
      step(4'hE, 1'b0);
`ifdef ACCUM_ILLEGAL_TRAP_EN
      check("ill_trap", E_TRAP);
      step(4'h1, 1'b0); check("ill_trap_hold", E_TRAP);
`else
      check("ill_nop_fetch", E_FETCH);
      step(4'h1, 1'b0); check("ill_nop_decode", E_DECODE);
`endif

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

`default_nettype wire

// File: doc/accum_control_unit.md
Name: accum_control_unit

Overview:
- Multicycle control FSM for the 16-bit accumulator CPU.
- Sits directly upstream of the accumulator datapath top and drives every one of its control inputs.
- Decodes the instruction opcode (IR[15:12]) and the ALU Zero flag into per-cycle strobes and mux selects for PC, Memory, ACC/SP registers and ALU.
- The datapath top zero-extends each narrow output onto its 16-bit control port.

Parameters:
- PC_STEP, 2, constant added to PC on fetch; selected by ALUSrcB code 0.

Ports:
- CLK  input  1  rising-edge clock.
- reset  input  1  asynchronous, active-low reset.
- opcode  input  4  IR[15:12], valid from DECODE onward.
- Zero  input  1  ALU zero flag, bit 0 of the datapath zero bus.
- PCWrite  output  1  unconditional PC load.
- Branch  output  1  conditional PC load, gated by Zero in the PC block.
- bneOrbeq  output  1  0 = BEQ, 1 = BNE.
- PCSrc  output  2  0 = ALU result, 1 = ZE, 2 = ALUOut.
- IRWrite  output  1  IR latch enable.
- MemAddr  output  2  0 = PC, 1 = SELeft, 2 = ALUOut.
- MemData  output  1  0 = ACC.
- MemWrite  output  1  memory write strobe.
- AccWrite  output  1  ACC load.
- SpWrite  output  1  SP load.
- ALUSrcA  output  2  0 = PC, 1 = ACC, 2 = SP.
- ALUSrcB  output  3  0 = PC_STEP, 1 = MDR, 2 = SE, 3 = ZE, 4 = SL1, 5 = zero.
- ALUOp  output  3  0 = ADD, 1 = SUB, 2 = AND, 3 = OR, 4 = PASSB.
- halted  output  1  core stopped by HALT.
- illegal  output  1  illegal-opcode trap taken.
- state_dbg  output  4  current state encoding.

Behaviour:
- ISA opcodes:
  - 0 HALT, 1 LDA, 2 STA, 3 ADD, 4 SUB, 5 AND, 6 ORR
  - 7 ADDI, 8 BEQ, 9 BNE, A JMP, B PUSH, C POP
  - D–F illegal
- Moore machine. Outputs are decoded combinationally from the state register and the registered opcode op_q. Any signal not listed for a state is 0.
- Reset (reset = 0): state = INIT, op_q = 0, halted = 0, illegal = 0, every output 0 immediately, including mid-instruction. No strobe survives reset.
- INIT: all outputs 0 -> FETCH.
- FETCH: MemAddr = 0, IRWrite = 1, SrcA = 0, SrcB = 0, ADD, PCSrc = 0, PCWrite = 1 -> DECODE.
- DECODE: op_q <= opcode; SrcA = 0, SrcB = 4, ADD (branch target into ALUOut). Next state by opcode:
  - 0 -> HALT
  - 1, 3–6 -> MEM_RD
  - 2 -> MEM_WR
  - 7 -> EXEC_I
  - 8/9 -> BRANCH
  - A -> JUMP
  - B -> PUSH_DEC
  - C -> POP_ADR
  - D–F -> see Optional Feature
- MEM_RD: MemAddr = 1 -> EXEC.
- EXEC: SrcA = 1, SrcB = 1, ALUOp = PASSB/ADD/SUB/AND/OR for op 1/3/4/5/6; AccWrite = 1 -> FETCH.
- MEM_WR: MemAddr = 1, MemData = 0, MemWrite = 1 -> FETCH.
- EXEC_I: SrcA = 1, SrcB = 2, ADD, AccWrite = 1 -> FETCH.
- BRANCH: SrcA = 1, SrcB = 5, SUB, Branch = 1, bneOrbeq = op_q[0], PCSrc = 2 -> FETCH. Zero is consumed only by the PC block; the FSM path is identical for taken and not-taken.
- JUMP: PCSrc = 1, PCWrite = 1 -> FETCH.
- PUSH_DEC: SrcA = 2, SrcB = 0, SUB, SpWrite = 1 -> PUSH_WR.
- PUSH_WR: MemAddr = 2, MemData = 0, MemWrite = 1 -> FETCH.
- POP_ADR: SrcA = 2, SrcB = 5, ADD -> POP_RD.
- POP_RD: MemAddr = 2, SrcA = 2, SrcB = 0, ADD, SpWrite = 1 -> POP_WB.
- POP_WB: SrcB = 1, PASSB, AccWrite = 1 -> FETCH.
- HALT: halted = 1, all strobes 0. Held until reset.
- Latency in cycles, FETCH through last state:
  - JMP, BEQ, BNE, STA, ADDI: 3
  - LDA, ALU ops, PUSH: 4
  - POP: 5
- At most one of PCWrite/Branch per cycle. MemWrite is never asserted together with IRWrite.

Optional Feature:
- Macro: ACCUM_ILLEGAL_TRAP_EN.
- Defined: opcodes D–F go DECODE -> TRAP. TRAP sets illegal = 1 and halted = 1, all strobes 0, held until reset.
- Undefined: D–F execute as NOP (DECODE -> FETCH, 2 cycles); illegal is tied 0 and the TRAP state is absent.

Decomposition:
- Package accum_ctrl_pkg holds:
  - opcode constants
  - state encoding (4-bit enum)
  - PCSrc/MemAddr/ALUSrcA/ALUSrcB select codes
  - ALUOp codes
- Sub-module accum_ctrl_decode: purely combinational (state, op_q) -> control word.
- The top holds the state register, op_q, and the halted/illegal flags.

Test Plan:
- Release reset, opcode = 1 -> INIT, FETCH (IRWrite = 1, PCWrite = 1), DECODE, MEM_RD (MemAddr = 1), EXEC (AccWrite = 1, ALUOp = 4), FETCH.
- Opcode = 9, Zero = 0 -> BRANCH cycle has Branch = 1, bneOrbeq = 1, PCSrc = 2, ALUOp = 1; next state FETCH.
- Opcode = B then C -> PUSH: SpWrite = 1 with ALUOp = 1, then MemWrite = 1 with MemAddr = 2. POP: 3 cycles ending in AccWrite = 1, ALUSrcB = 1.
- Opcode = 0 -> halted = 1 after DECODE; 10 further clocks with varying opcode leave all strobes 0.
- Assert reset asynchronously during PUSH_WR -> MemWrite drops to 0 before the next edge; state_dbg = INIT; fetch resumes on release.
- Opcode = E:
  - with ACCUM_ILLEGAL_TRAP_EN: illegal = 1, halted = 1.
  - without it: FETCH follows DECODE and illegal stays 0.
